fwd_scoreboard: RTL and testbench

Parametrised operand-forwarding and hazard unit for the pipelined core. It tracks every in-flight register-writing instruction from EX to writeback in a shift-register scoreboard. For each of NREAD source operands of the instruction in ID, it produces a registered bypass select. When the youngest producer's result will not be ready in time, for example load-use or other multi-cycle results, it raises a combinational stall. A saturating stall-cycle counter is included for performance monitoring.

---
 rtl/fwd_scoreboard.sv | 142 ++++++++++++++
 tb/tb_fwd_scoreboard.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand-forwarding and hazard unit.
//
// Tracks every in-flight register-writing instruction from EX (slot 0) to
// writeback (slot DEPTH-1) in a shift-register scoreboard. For each of the
// NREAD source operands of the ID instruction it computes a bypass select
// (registered into fwd_sel for use in EX) and raises a combinational stall
// when the youngest producer's result is not ready yet.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   id_valid        ID holds a real instruction
//   id_flush        kill the ID instruction this cycle
//   id_rd, id_wen   destination register / write enable of the ID instruction
//   id_lat          slot index at which the result becomes forwardable
//   id_rs, id_ren   packed source registers / per-port read enables
//   cnt_clr         synchronous clear of stall_cycles
//   stall           combinational; hold IF/ID and insert a bubble into EX
//   fwd_sel         registered per-port select: 0 = regfile, k+1 = bypass
//                   bus of the producer that was in slot k at capture
//   slot_valid      occupancy of each scoreboard slot
//   stall_cycles    saturating count of stalled cycles
module fwd_scoreboard #(
  parameter int unsigned NREAD = 2,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 32,
  localparam int unsigned LW   = $clog2(DEPTH),
  localparam int unsigned SELW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic                   id_flush,
  input  logic [AW-1:0]          id_rd,
  input  logic                   id_wen,
  input  logic [LW-1:0]          id_lat,
  input  logic [NREAD*AW-1:0]    id_rs,
  input  logic [NREAD-1:0]       id_ren,
  input  logic                   cnt_clr,
  output logic                   stall,
  output logic [NREAD*SELW-1:0]  fwd_sel,
  output logic [DEPTH-1:0]       slot_valid,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam logic [LW-1:0] LatMax = LW'(DEPTH - 1);

  // Scoreboard slots
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    rd_q  [DEPTH];
  logic [LW-1:0]    lat_q [DEPTH];

  logic [NREAD*SELW-1:0] fwd_sel_q;
  logic [NREAD*SELW-1:0] cand;
  logic [NREAD-1:0]      stall_req;
  logic [NREAD-1:0]      hit;
  logic [AW-1:0]         rs_cur;
  logic [CNT_W-1:0]      cnt_q;

  logic          capture;
  logic          entry_valid;
  logic [LW-1:0] lat_clamped;

  always_comb begin
    lat_clamped = (id_lat > LatMax) ? LatMax : id_lat;
  end

  // Per-port youngest-producer search. Only the first (youngest) match counts,
  // so an older ready copy of the same rd never hides a younger unready one.
  always_comb begin
    stall_req = '0;
    hit       = '0;
    cand      = '0;
    rs_cur    = '0;
    for (int p = 0; p < NREAD; p++) begin
      rs_cur = id_rs[p*AW +: AW];
      if (id_ren[p] && (rs_cur != '0)) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (!hit[p] && valid_q[k] && (rd_q[k] == rs_cur)) begin
            hit[p] = 1'b1;
            if (k >= int'(lat_q[k])) begin
              cand[p*SELW +: SELW] = SELW'(k + 1);
            end else begin
              stall_req[p] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    stall       = id_valid & ~id_flush & (|stall_req);
    capture     = id_valid & ~id_flush & ~stall;
    // x0 writes and non-writing instructions enter as bubbles.
    entry_valid = capture & id_wen & (id_rd != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= '0;
        lat_q[k] <= '0;
      end
    end else begin
      valid_q <= {valid_q[DEPTH-2:0], entry_valid};
      for (int k = 1; k < DEPTH; k++) begin
        rd_q[k]  <= rd_q[k-1];
        lat_q[k] <= lat_q[k-1];
      end
      rd_q[0]  <= id_rd;
      lat_q[0] <= lat_clamped;
    end
  end

  // Select follows the consumer into EX; a bubble in EX forwards nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_sel_q <= '0;
    end else if (capture) begin
      fwd_sel_q <= cand;
    end else begin
      fwd_sel_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fwd_sel      = fwd_sel_q;
  assign slot_valid   = valid_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed table-driven bench for fwd_scoreboard (NREAD=2, DEPTH=3, CNT_W=4).
module tb_fwd_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic       id_flush = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_wen = 1'b0;
  logic [1:0] id_lat = '0;
  logic [9:0] id_rs = '0;
  logic [1:0] id_ren = '0;
  logic       cnt_clr = 1'b0;
  logic       stall;
  logic [3:0] fwd_sel;
  logic [2:0] slot_valid;
  logic [3:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  fwd_scoreboard #(
    .NREAD(2),
    .DEPTH(3),
    .AW(5),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_valid(id_valid),
    .id_flush(id_flush),
    .id_rd(id_rd),
    .id_wen(id_wen),
    .id_lat(id_lat),
    .id_rs(id_rs),
    .id_ren(id_ren),
    .cnt_clr(cnt_clr),
    .stall(stall),
    .fwd_sel(fwd_sel),
    .slot_valid(slot_valid),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       flush;
    logic [4:0] rd;
    logic       wen;
    logic [1:0] lat;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] ren;
    logic       clr;
    logic       exp_stall;
    logic [1:0] exp_sel0;
    logic [1:0] exp_sel1;
    logic [2:0] exp_sv;
    logic [3:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic valid, input logic flush, input logic [4:0] rd,
                              input logic wen, input logic [1:0] lat, input logic [4:0] rs0,
                              input logic [4:0] rs1, input logic [1:0] ren, input logic clr,
                              input logic st, input logic [1:0] s0, input logic [1:0] s1,
                              input logic [2:0] sv, input logic [3:0] cnt);
    vec_t v;
    v.valid = valid; v.flush = flush; v.rd = rd; v.wen = wen; v.lat = lat;
    v.rs0 = rs0; v.rs1 = rs1; v.ren = ren; v.clr = clr;
    v.exp_stall = st; v.exp_sel0 = s0; v.exp_sel1 = s1; v.exp_sv = sv; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_flush = 1'b0; id_rd = '0; id_wen = 1'b0; id_lat = '0;
    id_rs = '0; id_ren = '0; cnt_clr = 1'b0;
  endtask

  // Drive one ID cycle, check stall before the edge and registered outputs after it.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    id_valid = v.valid; id_flush = v.flush; id_rd = v.rd; id_wen = v.wen; id_lat = v.lat;
    id_rs = {v.rs1, v.rs0}; id_ren = v.ren; cnt_clr = v.clr;
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(v.exp_stall));
    @(posedge clk);
    #1;
    chk({tag, ".sel0"}, 32'(fwd_sel[1:0]), 32'(v.exp_sel0));
    chk({tag, ".sel1"}, 32'(fwd_sel[3:2]), 32'(v.exp_sel1));
    chk({tag, ".slot_valid"}, 32'(slot_valid), 32'(v.exp_sv));
    chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(v.exp_cnt));
  endtask

  vec_t tbl [24];
  int   n_stall;

  function automatic logic [3:0] sat(input int n);
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  initial begin
    //            vld fl rd  we lat rs0 rs1 ren clr  st s0 s1 sv      cnt
    // ALU chain
    tbl[0]  = mk(1, 0, 5, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b001, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 5, 0, 2'b01, 0, 0, 1, 0, 3'b010, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b100, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0);
    // Load-use: one stall, then bypass from slot 1
    tbl[4]  = mk(1, 0, 7, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 3'b001, 0);
    tbl[5]  = mk(1, 0, 9, 1, 0, 0, 7, 2'b10, 0, 1, 0, 0, 3'b010, 1);
    tbl[6]  = mk(1, 0, 9, 1, 0, 0, 7, 2'b10, 0, 0, 0, 2, 3'b101, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b010, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b100, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 1);
    // Priority (youngest rd=3 wins), x0 writer never stored, x0 reads
    tbl[10] = mk(1, 0, 3, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b001, 1);
    tbl[11] = mk(1, 0, 3, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b011, 1);
    tbl[12] = mk(1, 0, 0, 1, 0, 3, 0, 2'b11, 0, 0, 1, 0, 3'b110, 1);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 3'b100, 1);
    // Producer in writeback slot, then gone: regfile
    tbl[14] = mk(1, 0, 0, 0, 0, 3, 0, 2'b01, 0, 0, 3, 0, 3'b000, 1);
    tbl[15] = mk(1, 0, 0, 0, 0, 3, 0, 2'b01, 0, 0, 0, 0, 3'b000, 1);
    // Flush during hazard
    tbl[16] = mk(1, 0, 7, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 3'b001, 1);
    tbl[17] = mk(1, 1, 4, 1, 0, 7, 0, 2'b01, 0, 0, 0, 0, 3'b010, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b100, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 1);
    // id_lat=3 clamps to 2: two stalls, then bypass from writeback slot
    tbl[20] = mk(1, 0, 6, 1, 3, 0, 0, 2'b00, 0, 0, 0, 0, 3'b001, 1);
    tbl[21] = mk(1, 0, 0, 0, 0, 6, 0, 2'b01, 0, 1, 0, 0, 3'b010, 2);
    tbl[22] = mk(1, 0, 0, 0, 0, 6, 0, 2'b01, 0, 1, 0, 0, 3'b100, 3);
    tbl[23] = mk(1, 0, 0, 0, 0, 6, 0, 2'b01, 0, 0, 3, 0, 3'b000, 3);

    // Reset state
    drive_idle();
    #2 rst = 1'b1;
    #1;
    chk("reset.slot_valid", 32'(slot_valid), 32'd0);
    chk("reset.fwd_sel", 32'(fwd_sel), 32'd0);
    chk("reset.stall_cycles", 32'(stall_cycles), 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Fill all slots (last capture forwards from slot 0), then a stalling consumer
    step(mk(1, 0, 10, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b001, 3), "fill0");
    step(mk(1, 0, 11, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b011, 3), "fill1");
    step(mk(1, 0, 8, 1, 2, 11, 0, 2'b01, 0, 0, 1, 0, 3'b111, 3), "fill2");
    @(negedge clk);
    id_valid = 1'b1; id_rd = '0; id_wen = 1'b0; id_rs = {5'd0, 5'd8}; id_ren = 2'b01;
    #1;
    chk("midrst.pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst.slot_valid", 32'(slot_valid), 32'd0);
    chk("midrst.stall", 32'(stall), 32'd0);
    chk("midrst.fwd_sel", 32'(fwd_sel), 32'd0);
    chk("midrst.stall_cycles", 32'(stall_cycles), 32'd0);
    #1;
    rst = 1'b0;
    drive_idle();

    // Counter saturation: 10 load-use rounds of two stall cycles each
    n_stall = 0;
    for (int r = 0; r < 10; r++) begin
      step(mk(1, 0, 12, 1, 2, 0, 0, 2'b00, 0, 0, 0, 0, 3'b001, sat(n_stall)), "cnt.prod");
      n_stall++;
      step(mk(1, 0, 0, 0, 0, 12, 0, 2'b01, 0, 1, 0, 0, 3'b010, sat(n_stall)), "cnt.st1");
      n_stall++;
      step(mk(1, 0, 0, 0, 0, 12, 0, 2'b01, 0, 1, 0, 0, 3'b100, sat(n_stall)), "cnt.st2");
      step(mk(1, 0, 0, 0, 0, 12, 0, 2'b01, 0, 0, 3, 0, 3'b000, sat(n_stall)), "cnt.cap");
    end
    chk("cnt.saturated", 32'(stall_cycles), 32'd15);

    // Clear wins over a concurrent stall; counting resumes afterwards
    step(mk(1, 0, 12, 1, 2, 0, 0, 2'b00, 0, 0, 0, 0, 3'b001, 15), "clr.prod");
    step(mk(1, 0, 0, 0, 0, 12, 0, 2'b01, 1, 1, 0, 0, 3'b010, 0), "clr.st");
    step(mk(1, 0, 0, 0, 0, 12, 0, 2'b01, 0, 1, 0, 0, 3'b100, 1), "clr.resume");
    step(mk(1, 0, 0, 0, 0, 12, 0, 2'b01, 0, 0, 3, 0, 3'b000, 1), "clr.cap");

    drive_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
